// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Arbiter states, default widths/burst length and the burst-counter helper.
package imem_arb_pkg;

   localparam int IMEM_AW_DEF    = 6;
   localparam int IMEM_DW_DEF    = 32;
   localparam int IMEM_BURST_DEF = 4;
   localparam int CNT_W          = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   // Burst counter increment that never passes the limit
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic [CNT_W-1:0] lim);
      return (cnt >= lim) ? lim : cnt + 4'd1;
   endfunction

endpackage

// File: rtl/imem_arb_resp.sv
// Per-requester response register: captures the ROM word on a grant
// and presents it with a one-cycle valid pulse on the following cycle.
module imem_arb_resp
   import imem_arb_pkg::*;
#(
   parameter int DW = IMEM_DW_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          i_gnt,
   input  logic [DW-1:0] i_rdata,
   output logic [DW-1:0] o_rdata,
   output logic          o_rvalid
);

   logic [DW-1:0] r_rdata;
   logic          r_rvalid;

   // Capture data on grant; data holds between grants, valid is a pulse
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= i_gnt;
         if (i_gnt) r_rdata <= i_rdata;
      end
   end

   assign o_rdata  = r_rdata;
   assign o_rvalid = r_rvalid;

endmodule

// File: rtl/imem_arbiter.sv
// Two-requester arbiter in front of a single-port combinational ROM.
// Grants are combinational, read data is returned one cycle later.
// Build option: define IMEM_ARB_FIXED_PRIO_EN for fixed priority
// (requester 0 always wins, burst limit and round-robin pointer unused);
// default build is round-robin with a burst limit per owner.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int AW    = IMEM_AW_DEF,
   parameter int DW    = IMEM_DW_DEF,
   parameter int BURST = IMEM_BURST_DEF
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          req0,
   input  logic          req1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   output logic          gnt0,
   output logic          gnt1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic          mem_en,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [CNT_W-1:0] C_BURST = CNT_W'(BURST);

   arb_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_rr;      // 0 favours requester 0 on an IDLE tie

   arb_state_e       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_rr_nxt;
   logic             w_win0;
   logic             w_win1;

   // State register; reset wins over every other update
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rr    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rr    <= w_rr_nxt;
      end
   end

`ifdef IMEM_ARB_FIXED_PRIO_EN
   // Next state: requester 0 always wins, no burst limit
   always_comb begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_rr_nxt    = 1'b0;
      w_win0      = 1'b0;
      w_win1      = 1'b0;
      if (req0) begin
         w_win0      = 1'b1;
         w_state_nxt = OWN0;
         w_cnt_nxt   = 4'd1;
      end else if (req1) begin
         w_win1      = 1'b1;
         w_state_nxt = OWN1;
         w_cnt_nxt   = 4'd1;
      end
   end
`else
   // Next state: owner keeps the port until it stops or its burst expires
   // while the other side waits; the counter only advances under contention
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rr_nxt    = r_rr;
      w_win0      = 1'b0;
      w_win1      = 1'b0;
      case (r_state)
         IDLE: begin
            if (req0 && (!req1 || !r_rr)) begin
               w_win0      = 1'b1;
               w_state_nxt = OWN0;
               w_cnt_nxt   = 4'd1;
            end else if (req1) begin
               w_win1      = 1'b1;
               w_state_nxt = OWN1;
               w_cnt_nxt   = 4'd1;
            end else begin
               w_cnt_nxt   = '0;
            end
         end
         OWN0: begin
            if (req0 && (!req1 || r_cnt < C_BURST)) begin
               w_win0    = 1'b1;
               w_cnt_nxt = req1 ? sat_inc(r_cnt, C_BURST) : 4'd1;
            end else if (req1) begin
               // burst expiry (req0 still up) or owner dropped
               w_win1      = 1'b1;
               w_state_nxt = OWN1;
               w_cnt_nxt   = 4'd1;
               if (req0) w_rr_nxt = 1'b0;
            end else begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_rr_nxt    = 1'b1;
            end
         end
         OWN1: begin
            if (req1 && (!req0 || r_cnt < C_BURST)) begin
               w_win1    = 1'b1;
               w_cnt_nxt = req0 ? sat_inc(r_cnt, C_BURST) : 4'd1;
            end else if (req0) begin
               w_win0      = 1'b1;
               w_state_nxt = OWN0;
               w_cnt_nxt   = 4'd1;
               if (req1) w_rr_nxt = 1'b1;
            end else begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_rr_nxt    = 1'b0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end
`endif

   // Outputs: grants masked during reset, ROM address follows the winner
   always_comb begin
      gnt0     = w_win0 & ~RST;
      gnt1     = w_win1 & ~RST;
      mem_en   = gnt0 | gnt1;
      mem_addr = '0;
      if (gnt0)      mem_addr = addr0;
      else if (gnt1) mem_addr = addr1;
   end

   imem_arb_resp #(.DW(DW)) u_resp0 (
      .CLK     (CLK),
      .RST     (RST),
      .i_gnt   (gnt0),
      .i_rdata (mem_rdata),
      .o_rdata (rdata0),
      .o_rvalid(rvalid0)
   );

   imem_arb_resp #(.DW(DW)) u_resp1 (
      .CLK     (CLK),
      .RST     (RST),
      .i_gnt   (gnt1),
      .i_rdata (mem_rdata),
      .o_rdata (rdata1),
      .o_rvalid(rvalid1)
   );

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: a rule-level arbitration model predicts
// every grant and queues the expected ROM word; a monitor pops on rvalid.
module tb_imem_arbiter;

   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int BURST = 4;

   logic          CLK = 1'b0;
   logic          RST;
   logic          req0, req1;
   logic [AW-1:0] addr0, addr1;
   logic          gnt0, gnt1;
   logic [DW-1:0] rdata0, rdata1;
   logic          rvalid0, rvalid1;
   logic          mem_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata;

   logic [DW-1:0] rom [0:(1<<AW)-1];
   assign mem_rdata = rom[mem_addr];

   always #5 CLK = ~CLK;

   imem_arbiter #(.AW(AW), .DW(DW), .BURST(BURST)) dut (
      .CLK(CLK), .RST(RST),
      .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
   );

   typedef struct packed {
      logic [31:0]   cyc;
      logic [DW-1:0] data;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_en = 0;
   bit lg0 = 0, lg1 = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge CLK) cyc++;

   // Reference model: owner, burst count and tie pointer as plain integers
   int m_own = -1, m_cnt = 0, m_rr = 0;
   int win, n, o;
   bit r [2];
   logic [AW-1:0] exp_addr;

   always @(negedge CLK) begin
      r[0] = req0;
      r[1] = req1;
      if (RST === 1'b1) begin
         win = -1; m_own = -1; m_cnt = 0; m_rr = 0;
      end else begin
`ifdef IMEM_ARB_FIXED_PRIO_EN
         win = r[0] ? 0 : (r[1] ? 1 : -1);
`else
         if (m_own < 0) begin
            if (r[0] && r[1]) win = m_rr;
            else if (r[0])    win = 0;
            else if (r[1])    win = 1;
            else              win = -1;
            m_cnt = (win < 0) ? 0 : 1;
         end else begin
            n = m_own;
            o = 1 - n;
            if (r[n] && (!r[o] || m_cnt < BURST)) begin
               win = n;
               m_cnt = r[o] ? ((m_cnt + 1 > BURST) ? BURST : m_cnt + 1) : 1;
            end else if (r[o]) begin
               win = o;
               if (r[n]) m_rr = n;
               m_cnt = 1;
            end else begin
               win = -1; m_cnt = 0; m_rr = o;
            end
         end
`endif
         m_own = win;
      end
      exp_addr = (win == 0) ? addr0 : (win == 1) ? addr1 : '0;
      chk("gnt0", gnt0, (win == 0));
      chk("gnt1", gnt1, (win == 1));
      chk("mem_en", mem_en, (win >= 0));
      chk("mem_addr", mem_addr, exp_addr);
      if (win == 0) q0.push_back('{cyc: cyc, data: rom[addr0]});
      if (win == 1) q1.push_back('{cyc: cyc, data: rom[addr1]});
      lg0 = (gnt0 === 1'b1);
      lg1 = (gnt1 === 1'b1);
   end

   // Monitor: pops the scoreboard whenever a response is presented
   logic [DW-1:0] last0 = '0, last1 = '0;
   exp_t e;

   always @(negedge CLK) begin
      if (mon_en) begin
         while (q0.size() > 0 && int'(q0[0].cyc) < cyc - 1) begin
            e = q0.pop_front();
            chk("rvalid0_missing", 1'b0, 1'b1);
         end
         while (q1.size() > 0 && int'(q1[0].cyc) < cyc - 1) begin
            e = q1.pop_front();
            chk("rvalid1_missing", 1'b0, 1'b1);
         end
         if (rvalid0 === 1'b1) begin
            if (q0.size() == 0) chk("rvalid0_spurious", 1'b1, 1'b0);
            else begin
               e = q0.pop_front();
               chk("rdata0", rdata0, e.data);
               chk("rvalid0_latency", cyc, e.cyc + 1);
               last0 = e.data;
            end
         end else begin
            chk("rvalid0_low", rvalid0, 1'b0);
            chk("rdata0_hold", rdata0, last0);
         end
         if (rvalid1 === 1'b1) begin
            if (q1.size() == 0) chk("rvalid1_spurious", 1'b1, 1'b0);
            else begin
               e = q1.pop_front();
               chk("rdata1", rdata1, e.data);
               chk("rvalid1_latency", cyc, e.cyc + 1);
               last1 = e.data;
            end
         end else begin
            chk("rvalid1_low", rvalid1, 1'b0);
            chk("rdata1_hold", rdata1, last1);
         end
         if (RST === 1'b1) begin
            last0 = '0;
            last1 = '0;
         end
      end
   end

   task automatic do_reset();
      @(posedge CLK); #1;
      RST = 1'b1; req0 = 1'b0; req1 = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   task automatic step();
      @(posedge CLK); #1;
   endtask

   logic [11:0]   pat_got, pat_exp;
   logic [DW-1:0] w5;

   initial begin
      for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
      RST = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
      repeat (2) @(posedge CLK);
      #1;
      // request during reset must not be granted
      req0 = 1'b1; addr0 = 6'd5;
      @(negedge CLK);
      chk("rst_gnt0", gnt0, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      step();
      RST = 1'b0;
      mon_en = 1'b1;
      // single request to word 5, held through reset
      @(negedge CLK);
      chk("rst_rvalid0", rvalid0, 1'b0);
      chk("rst_rdata0", rdata0, '0);
      chk("single_gnt0", gnt0, 1'b1);
      chk("single_addr", mem_addr, 6'd5);
      w5 = rom[5];
      step();
      req0 = 1'b0;
      @(negedge CLK);
      chk("single_rvalid0", rvalid0, 1'b1);
      chk("single_rdata0", rdata0, w5);

      // tie from IDLE after reset, then owner drops with the other pending
      do_reset();
      req0 = 1'b1; req1 = 1'b1; addr0 = AW'($urandom); addr1 = AW'($urandom);
      @(negedge CLK);
      chk("tie_after_reset_gnt0", gnt0, 1'b1);
      step();
      req0 = 1'b0;
      @(negedge CLK);
      chk("drop_switch_gnt1", gnt1, 1'b1);
      step();
      req1 = 1'b0;
      step();
      // requester 0 owns alone then idles; next tie should go to 1
      req0 = 1'b1; addr0 = AW'($urandom);
      step();
      req0 = 1'b0;
      step();
      req0 = 1'b1; req1 = 1'b1; addr0 = AW'($urandom); addr1 = AW'($urandom);
      @(negedge CLK);
`ifdef IMEM_ARB_FIXED_PRIO_EN
      chk("tie_after_own0_gnt0", gnt0, 1'b1);
`else
      chk("tie_after_own0_gnt1", gnt1, 1'b1);
`endif
      step();
      if (lg0) req0 = 1'b0;
      if (lg1) req1 = 1'b0;
      step();
      req0 = 1'b0; req1 = 1'b0;

      // both requesting continuously from reset: burst pattern
      do_reset();
      req0 = 1'b1; req1 = 1'b1; addr0 = AW'($urandom); addr1 = AW'($urandom);
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         pat_got[i] = gnt1;
         step();
         if (lg0) addr0 = AW'($urandom);
         if (lg1) addr1 = AW'($urandom);
      end
      for (int i = 0; i < 12; i++) begin
`ifdef IMEM_ARB_FIXED_PRIO_EN
         pat_exp[i] = 1'b0;
`else
         pat_exp[i] = ((i / BURST) % 2) == 1;
`endif
      end
      chk("burst_pattern", pat_got, pat_exp);

      // reset in the cycle requester 1 would be granted
      do_reset();
      req1 = 1'b1; addr1 = AW'($urandom);
      step();
      addr1 = AW'($urandom);
      RST = 1'b1;
      @(negedge CLK);
      chk("rst_cycle_gnt1", gnt1, 1'b0);
      step();
      RST = 1'b0;
      @(negedge CLK);
      chk("post_rst_rvalid1", rvalid1, 1'b0);
      chk("post_rst_rdata1", rdata1, '0);
      step();
      req1 = 1'b0;

      // randomized traffic with occasional reset
      for (int c = 0; c < 3000; c++) begin
         step();
         RST = ($urandom_range(0, 249) == 0);
         if (!req0 || lg0) begin
            req0  = ($urandom_range(0, 99) < 65);
            addr0 = AW'($urandom);
         end
         if (!req1 || lg1) begin
            req1  = ($urandom_range(0, 99) < 65);
            addr1 = AW'($urandom);
         end
      end
      step();
      RST = 1'b0; req0 = 1'b0; req1 = 1'b0;
      repeat (4) step();
      @(negedge CLK);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
